// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: sequencer state encoding and loss-counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABLE     = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } seq_state_t;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of PLL lock input and the sequenced reset/status outputs.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level-based status.
interface reset_sequencer_if;
  import clk_rst_pkg::*;

  logic                  locked;
  logic                  periph_rst;
  logic                  core_rst;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  // The sequencer consumes lock and drives the rails.
  modport master (
    input  locked,
    output periph_rst, core_rst, ready, lock_loss_cnt
  );

  // The PLL side / system side sees the opposite directions.
  modport slave (
    output locked,
    input  periph_rst, core_rst, ready, lock_loss_cnt
  );

endinterface

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser for asynchronous level inputs (lock flags, buttons).
// Latency: STAGES clock edges from input change to output change.
// Backpressure: none; a pulse shorter than one clock period may be lost.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the raw input through the flop chain; clear the whole chain on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// PLL-lock driven reset sequencer: releases peripheral then core rail, counts lock losses.
// Latency: rails move SYNC_STAGES edges after lock is lost; release after STABLE/GAP cycles.
// Backpressure: none; outputs are free-running registered levels.
module reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter  int SYNC_STAGES   = 2,
  parameter  int STABLE_CYCLES = 1024,
  parameter  int GAP_CYCLES    = 16,
  localparam int CNT_W         = cnt_width(STABLE_CYCLES, GAP_CYCLES)
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  reset_sequencer_if.master seq
);

  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(GAP_CYCLES - 1);

  logic                  locked_s;
  seq_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  loss_evt;
  logic                  periph_rst_d, core_rst_d, ready_d;
  logic                  periph_rst_q, core_rst_q, ready_q;
  logic [LOSS_CNT_W-1:0] loss_cnt;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk_100mhz),
    .rst (rst),
    .d   (seq.locked),
    .q   (locked_s)
  );

  // State, shared counter and the rail outputs all update on the same edge.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      periph_rst_q <= 1'b1;
      core_rst_q   <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      periph_rst_q <= periph_rst_d;
      core_rst_q   <= core_rst_d;
      ready_q      <= ready_d;
    end
  end

  // Next state and shared counter; a lock drop always beats a terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_evt  = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (locked_s) begin
          state_nxt = STABLE;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_TC) begin
          state_nxt = REL_PERIPH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      REL_PERIPH: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          loss_evt  = 1'b1;
        end else if (cnt == GAP_TC) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          loss_evt  = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Rail levels decoded from the state being entered, so they move with the state.
  always_comb begin
    periph_rst_d = (state_nxt == WAIT_LOCK) || (state_nxt == STABLE);
    core_rst_d   = (state_nxt != RUN);
    ready_d      = (state_nxt == RUN);
  end

  // Saturating debug count of losses after at least one rail had been released.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (loss_evt && (loss_cnt != LOSS_CNT_MAX)) begin
      loss_cnt <= loss_cnt + LOSS_CNT_W'(1);
    end
  end

  assign seq.periph_rst    = periph_rst_q;
  assign seq.core_rst      = core_rst_q;
  assign seq.ready         = ready_q;
  assign seq.lock_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a timing-level scoreboard.
// Latency: expected rail levels predicted two edges ahead from the raw lock history.
// Backpressure: n/a.
module tb_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int GAP    = 4;

  typedef struct packed {
    logic       periph;
    logic       core;
    logic       ready;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  reset_sequencer_if sif ();

  reset_sequencer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk_100mhz (clk),
    .rst        (rst),
    .seq        (sif)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   run_len = 0;
  int   mcnt = 0;
  exp_t sb[$];

  function automatic exp_t observed();
    exp_t o;
    o = {sif.periph_rst, sif.core_rst, sif.ready, sif.lock_loss_cnt};
    return o;
  endfunction

  task automatic check_val(input string tag, input exp_t obs, input exp_t exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed periph=%b core=%b ready=%b cnt=%0d expected periph=%b core=%b ready=%b cnt=%0d",
             tag, obs.periph, obs.core, obs.ready, obs.cnt,
             exp_v.periph, exp_v.core, exp_v.ready, exp_v.cnt);
    end
  endtask

  // After any reset the synchroniser holds zeros, so the first two edges see no lock.
  task automatic prime();
    exp_t e;
    sb.delete();
    run_len = 0;
    mcnt    = 0;
    edge_n  = 0;
    e = {1'b1, 1'b1, 1'b0, 8'd0};
    sb.push_back(e);
    sb.push_back(e);
  endtask

  // Drive one lock sample, predict the outputs SYNC edges later, then check this edge.
  task automatic drive(input logic l);
    exp_t e;
    exp_t got;
    bit   rel_before;
    sif.locked = l;
    rel_before = (run_len >= STABLE + 1);
    run_len    = l ? run_len + 1 : 0;
    if (!l && rel_before && mcnt < 255) mcnt++;
    e.periph = !(run_len >= STABLE + 1);
    e.ready  = (run_len >= STABLE + GAP + 1);
    e.core   = !e.ready;
    e.cnt    = 8'(mcnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    edge_n++;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty edge %0d observed none expected entry", edge_n);
    end else begin
      got = sb.pop_front();
      check_val($sformatf("edge_%0d", edge_n), observed(), got);
    end
    @(negedge clk);
  endtask

  task automatic run(input logic l, input int n);
    for (int i = 0; i < n; i++) drive(l);
  endtask

  initial begin
    exp_t rst_v;
    exp_t tmp;
    rst_v = {1'b1, 1'b1, 1'b0, 8'd0};
    rst = 1'b1;
    sif.locked = 1'b0;

    @(negedge clk);
    check_val("por_reset", observed(), rst_v);
    rst = 1'b0;
    prime();

    // Clean lock: periph falls at edge 11, core/ready at edge 15.
    run(1'b1, 20);
    // Loss in RUN, then a relock interrupted while still in STABLE.
    run(1'b0, 3);
    run(1'b1, 5);
    run(1'b0, 2);
    run(1'b1, 20);
    // Single-edge drop in RUN must still be caught.
    run(1'b0, 1);
    run(1'b1, 20);
    run(1'b0, 4);
    run(1'b1, 20);

    tmp = {1'b0, 1'b0, 1'b1, 8'd3};
    check_val("run_cnt3_before_rst", observed(), tmp);

    // Asynchronous reset pulse between edges while in RUN.
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_mid", observed(), rst_v);
    #1;
    rst = 1'b0;
    prime();

    // Drop exactly when the STABLE counter hits terminal count.
    run(1'b1, STABLE);
    run(1'b0, 1);
    run(1'b1, 20);
    // Loss during the peripheral-to-core gap.
    run(1'b0, 3);
    run(1'b1, STABLE + 2);
    run(1'b0, 2);
    run(1'b1, 20);

    // Saturation: 260 loss/relock cycles.
    for (int c = 0; c < 260; c++) begin
      run(1'b0, 2);
      run(1'b1, STABLE + 3);
    end
    run(1'b1, 5);

    tmp = {1'b0, 1'b0, 1'b1, 8'd255};
    check_val("saturated_255", observed(), tmp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
